run_detector: RTL and testbench

Parametrised consecutive-ones detector for serial control inputs. It is the generalised successor of the team's fixed two-in-a-row Moore FSM, with the following additions:
- configurable run length;
- a sample-qualifier input;
- a synchronous clear;
- a one-cycle detection pulse;
- a wrapping event counter with sticky overflow.

It sits between an input sampler and downstream control logic that needs a registered "w has been high N samples running" flag.

---
 rtl/run_detector_pkg.sv | 30 +++
 rtl/run_detector_evcnt.sv | 55 +++++
 rtl/run_detector.sv | 159 +++++++++++++++
 tb/tb_run_detector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_detector_pkg.sv
// ============================================================================
//  Module  : run_detector_pkg
//  Purpose : Shared types and parameter checks for the run_detector block.
//            Holds the detector state encoding and a legality function for
//            the RUN_LEN / CNT_W parameters.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package run_detector_pkg;

    // Detector state. 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        DET   = 2'b10
    } state_t;

    localparam int c_run_len_min = 1;
    localparam int c_run_len_max = 255;
    localparam int c_cnt_w_min   = 2;

    function automatic logic run_detector_params_ok(input int run_len, input int cnt_w);
        return (run_len >= c_run_len_min) && (run_len <= c_run_len_max) &&
               (cnt_w >= c_cnt_w_min);
    endfunction

endpackage

`default_nettype wire

// File: rtl/run_detector_evcnt.sv
// ============================================================================
//  Module  : run_detector_evcnt
//  Purpose : CNT_W-bit wrapping event counter with a sticky overflow flag.
//  Ports   : clk   - clock, rising edge
//            reset - asynchronous active-high reset
//            clr   - synchronous clear (wins over inc)
//            inc   - count one event on this edge
//            count - current event count, wraps modulo 2^CNT_W
//            ovf   - sticky, set when count wraps from all-ones to zero
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module run_detector_evcnt
    import run_detector_pkg::*;
#(
    parameter int CNT_W = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic [CNT_W-1:0] w_next;
    logic             w_carry;

    // Carry out of the increment marks the all-ones -> zero wrap.
    assign {w_carry, w_next} = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (inc) begin
            r_count <= w_next;
            if (w_carry) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign count = r_count;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/run_detector.sv
// ============================================================================
//  Module  : run_detector
//  Purpose : Consecutive-ones detector. Raises z once RUN_LEN qualified ones
//            have been seen in a row, pulses hit on entry to detection and
//            counts detections with a wrapping counter and sticky overflow.
//  Ports   : clk      - clock, rising edge
//            reset    - asynchronous active-high reset
//            clr      - synchronous clear
//            en       - sample qualifier for w
//            w        - serial input
//            z        - high while a full run is being observed
//            hit      - one-cycle pulse on entry to detection
//            run_cnt  - current run length, saturating at RUN_LEN
//            hits     - detection count (wraps)
//            hits_ovf - sticky wrap flag for hits
//            max_run  - longest qualified run since reset/clr
//                       (only with RUN_DETECTOR_MAXRUN_EN defined)
//  Config  : RUN_DETECTOR_MAXRUN_EN enables the max_run output.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module run_detector
    import run_detector_pkg::*;
#(
    parameter  int RUN_LEN = 2,
    parameter  int CNT_W   = 8,
    localparam int RUN_W   = $clog2(RUN_LEN + 1)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             w,
    output logic             z,
    output logic             hit,
    output logic [RUN_W-1:0] run_cnt,
    output logic [CNT_W-1:0] hits,
    output logic             hits_ovf
`ifdef RUN_DETECTOR_MAXRUN_EN
    ,
    output logic [CNT_W-1:0] max_run
`endif
);

    if (!run_detector_params_ok(RUN_LEN, CNT_W)) begin : g_param_check
        $error("run_detector: RUN_LEN must be 1..255 and CNT_W must be >= 2");
    end

    localparam logic [RUN_W-1:0] c_run_max  = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] c_run_last = RUN_W'(RUN_LEN - 1);
    localparam logic [RUN_W-1:0] c_run_one  = RUN_W'(1);

    state_t           r_state;
    logic [RUN_W-1:0] r_run;
    logic             r_z;
    logic             r_hit;
    logic             w_state_ok;
    logic             w_enter_det;

    assign w_state_ok = (r_state == IDLE) || (r_state == COUNT) || (r_state == DET);

    // A qualified 1 that completes the run: either the first 1 when a
    // single sample suffices, or the 1 that lifts run_cnt from RUN_LEN-1.
    assign w_enter_det = en && w &&
                         (((r_state == IDLE)  && (RUN_LEN == 1)) ||
                          ((r_state == COUNT) && (r_run == c_run_last)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_run   <= '0;
            r_z     <= 1'b0;
            r_hit   <= 1'b0;
        end else if (clr) begin
            r_state <= IDLE;
            r_run   <= '0;
            r_z     <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (!w_state_ok) begin
                r_state <= IDLE;
                r_run   <= '0;
                r_z     <= 1'b0;
            end else if (en) begin
                if (!w) begin
                    r_state <= IDLE;
                    r_run   <= '0;
                    r_z     <= 1'b0;
                end else if (w_enter_det) begin
                    r_state <= DET;
                    r_run   <= c_run_max;
                    r_z     <= 1'b1;
                    r_hit   <= 1'b1;
                end else if (r_state == IDLE) begin
                    r_state <= COUNT;
                    r_run   <= c_run_one;
                end else if (r_state == COUNT) begin
                    r_run   <= r_run + c_run_one;
                end
                // DET with w=1 holds state and run_cnt.
            end
        end
    end

    run_detector_evcnt #(
        .CNT_W (CNT_W)
    ) u_evcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (w_enter_det),
        .count (hits),
        .ovf   (hits_ovf)
    );

    assign z       = r_z;
    assign hit     = r_hit;
    assign run_cnt = r_run;

`ifdef RUN_DETECTOR_MAXRUN_EN
    // Raw run length, independent of RUN_LEN, saturating at all-ones.
    logic [CNT_W-1:0] r_raw;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] w_raw_next;

    always_comb begin
        w_raw_next = r_raw;
        if (en) begin
            if (!w) begin
                w_raw_next = '0;
            end else if (!(&r_raw)) begin
                w_raw_next = r_raw + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_raw <= '0;
            r_max <= '0;
        end else if (clr) begin
            r_raw <= '0;
            r_max <= '0;
        end else begin
            r_raw <= w_raw_next;
            if (w_raw_next > r_max) begin
                r_max <= w_raw_next;
            end
        end
    end

    assign max_run = r_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_run_detector.sv
// ============================================================================
//  Module  : tb_run_detector
//  Purpose : Self-checking bench for run_detector. Several instances with
//            different RUN_LEN / CNT_W share clock and reset; each is driven
//            by its own directed sequence with hand-computed expectations.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_run_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // u2: RUN_LEN=2, CNT_W=8
    logic       clr_2, en_2, w_2, z_2, hit_2, ovf_2;
    logic [1:0] run_2;
    logic [7:0] hits_2;
    // u3: RUN_LEN=3, CNT_W=8
    logic       clr_3, en_3, w_3, z_3, hit_3, ovf_3;
    logic [1:0] run_3;
    logic [7:0] hits_3;
    // u1: RUN_LEN=1, CNT_W=8
    logic       clr_1, en_1, w_1, z_1, hit_1, ovf_1;
    logic [0:0] run_1;
    logic [7:0] hits_1;
    // uw: RUN_LEN=2, CNT_W=2
    logic       clr_w, en_w, w_w, z_w, hit_w, ovf_w;
    logic [1:0] run_w;
    logic [1:0] hits_w;
    // u4: RUN_LEN=4, CNT_W=8
    logic       clr_4, en_4, w_4, z_4, hit_4, ovf_4;
    logic [2:0] run_4;
    logic [7:0] hits_4;
`ifdef RUN_DETECTOR_MAXRUN_EN
    logic [7:0] max_2, max_3, max_1, max_4;
    logic [1:0] max_w;
`endif

    run_detector #(.RUN_LEN(2), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .clr(clr_2), .en(en_2), .w(w_2), .z(z_2), .hit(hit_2),
        .run_cnt(run_2), .hits(hits_2), .hits_ovf(ovf_2)
`ifdef RUN_DETECTOR_MAXRUN_EN
        , .max_run(max_2)
`endif
    );
    run_detector #(.RUN_LEN(3), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .clr(clr_3), .en(en_3), .w(w_3), .z(z_3), .hit(hit_3),
        .run_cnt(run_3), .hits(hits_3), .hits_ovf(ovf_3)
`ifdef RUN_DETECTOR_MAXRUN_EN
        , .max_run(max_3)
`endif
    );
    run_detector #(.RUN_LEN(1), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .clr(clr_1), .en(en_1), .w(w_1), .z(z_1), .hit(hit_1),
        .run_cnt(run_1), .hits(hits_1), .hits_ovf(ovf_1)
`ifdef RUN_DETECTOR_MAXRUN_EN
        , .max_run(max_1)
`endif
    );
    run_detector #(.RUN_LEN(2), .CNT_W(2)) uw (
        .clk(clk), .reset(reset), .clr(clr_w), .en(en_w), .w(w_w), .z(z_w), .hit(hit_w),
        .run_cnt(run_w), .hits(hits_w), .hits_ovf(ovf_w)
`ifdef RUN_DETECTOR_MAXRUN_EN
        , .max_run(max_w)
`endif
    );
    run_detector #(.RUN_LEN(4), .CNT_W(8)) u4 (
        .clk(clk), .reset(reset), .clr(clr_4), .en(en_4), .w(w_4), .z(z_4), .hit(hit_4),
        .run_cnt(run_4), .hits(hits_4), .hits_ovf(ovf_4)
`ifdef RUN_DETECTOR_MAXRUN_EN
        , .max_run(max_4)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic clr, en, w;
        logic z, hit;
        int   run, hits;
        logic ovf;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl[NV];

    int en3_seq[5]  = '{1, 0, 0, 1, 1};
    int run3_exp[5] = '{1, 1, 1, 2, 3};
    int z3_exp[5]   = '{0, 0, 0, 0, 1};
    int w1_seq[4]   = '{1, 0, 1, 0};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge, outputs checked
    // 1 time unit after the following rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            clr en w   z hit run hits ovf
        tbl = '{
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0},
            '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 2, 1'b0},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2, 2, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2, 2, 1'b0},
            '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 1, 1'b0},
            '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0}
        };

        {clr_2, en_2, w_2} = '0;
        {clr_3, en_3, w_3} = '0;
        {clr_1, en_1, w_1} = '0;
        {clr_w, en_w, w_w} = '0;
        {clr_4, en_4, w_4} = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("reset.z",    int'(z_2),    0);
        chk("reset.hit",  int'(hit_2),  0);
        chk("reset.run",  int'(run_2),  0);
        chk("reset.hits", int'(hits_2), 0);
        chk("reset.ovf",  int'(ovf_2),  0);
`ifdef RUN_DETECTOR_MAXRUN_EN
        chk("reset.max_run", int'(max_2), 0);
`endif
        tick();
        tick();
        reset = 1'b0;

        // ---- table-driven sequence, RUN_LEN=2 ----
        for (int i = 0; i < NV; i++) begin
            clr_2 = tbl[i].clr;
            en_2  = tbl[i].en;
            w_2   = tbl[i].w;
            tick();
            chk($sformatf("tbl%0d.z", i),    int'(z_2),    int'(tbl[i].z));
            chk($sformatf("tbl%0d.hit", i),  int'(hit_2),  int'(tbl[i].hit));
            chk($sformatf("tbl%0d.run", i),  int'(run_2),  tbl[i].run);
            chk($sformatf("tbl%0d.hits", i), int'(hits_2), tbl[i].hits);
            chk($sformatf("tbl%0d.ovf", i),  int'(ovf_2),  int'(tbl[i].ovf));
        end
        {clr_2, en_2, w_2} = '0;

        // ---- qualification gaps, RUN_LEN=3 ----
        w_3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en_3 = en3_seq[i][0];
            tick();
            chk($sformatf("gap%0d.run", i), int'(run_3), run3_exp[i]);
            chk($sformatf("gap%0d.z", i),   int'(z_3),   z3_exp[i]);
            chk($sformatf("gap%0d.hit", i), int'(hit_3), z3_exp[i]);
        end
        en_3 = 1'b1;
        tick();
        chk("gap_hold.hit",  int'(hit_3),  0);
        chk("gap_hold.run",  int'(run_3),  3);
        chk("gap_hold.hits", int'(hits_3), 1);
        {en_3, w_3} = '0;

        // ---- single-bit runs, RUN_LEN=1 ----
        en_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            w_1 = w1_seq[i][0];
            tick();
            chk($sformatf("rl1_%0d.hit", i), int'(hit_1), w1_seq[i]);
            chk($sformatf("rl1_%0d.z", i),   int'(z_1),   w1_seq[i]);
            chk($sformatf("rl1_%0d.run", i), int'(run_1), w1_seq[i]);
        end
        chk("rl1.hits", int'(hits_1), 2);
        {en_1, w_1} = '0;

        // ---- counter wrap, CNT_W=2 ----
        en_w = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            w_w = 1'b1;
            tick();
            tick();
            chk($sformatf("wrap%0d.hits", k), int'(hits_w), k % 4);
            chk($sformatf("wrap%0d.ovf", k),  int'(ovf_w),  (k == 4) ? 1 : 0);
            if (k < 4) begin
                w_w = 1'b0;
                tick();
            end
        end
        clr_w = 1'b1;
        tick();
        chk("wrapclr.z",    int'(z_w),    0);
        chk("wrapclr.hit",  int'(hit_w),  0);
        chk("wrapclr.run",  int'(run_w),  0);
        chk("wrapclr.hits", int'(hits_w), 0);
        chk("wrapclr.ovf",  int'(ovf_w),  0);
        {clr_w, en_w, w_w} = '0;

        // ---- clr and reset mid-run, RUN_LEN=4 ----
        en_4 = 1'b1;
        w_4  = 1'b1;
        tick();
        tick();
        chk("clr4.pre_run", int'(run_4), 2);
        clr_4 = 1'b1;
        tick();
        chk("clr4.run", int'(run_4), 0);
        chk("clr4.z",   int'(z_4),   0);
        clr_4 = 1'b0;
        repeat (4) tick();
        chk("rst4.pre_z",    int'(z_4),    1);
        chk("rst4.pre_hits", int'(hits_4), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst4.run",  int'(run_4),  0);
        chk("rst4.z",    int'(z_4),    0);
        chk("rst4.hits", int'(hits_4), 0);
        #1 reset = 1'b0;
        tick();
        chk("rst4.post_run", int'(run_4), 1);
        {en_4, w_4} = '0;

`ifdef RUN_DETECTOR_MAXRUN_EN
        // ---- longest-run tracking, RUN_LEN=2 ----
        clr_2 = 1'b1;
        tick();
        clr_2 = 1'b0;
        en_2  = 1'b1;
        w_2   = 1'b1;
        repeat (5) tick();
        chk("max.run_capped", int'(run_2), 2);
        chk("max.after5",     int'(max_2), 5);
        w_2 = 1'b0;
        tick();
        w_2 = 1'b1;
        repeat (3) tick();
        w_2 = 1'b0;
        tick();
        chk("max.after3", int'(max_2), 5);
        chk("max.run0",   int'(run_2), 0);
        {en_2, w_2} = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
